// File: rtl/w_74hc138_sync_if.sv
// Port bundle for the clocked 3-to-8 decoder: enables, priority code with strobe,
// scan request, output handshake and the registered decoder outputs.
interface w_74hc138_sync_if;
    logic       G1;
    logic       G2A_n;
    logic       G2B_n;
    logic [2:0] DataIn;
    logic       GS_n;
    logic       scan;
    logic       out_ready;
    logic       in_ready;
    logic [7:0] DataOut;
    logic       out_valid;
    logic [2:0] scan_idx;

    modport master (
        output G1, G2A_n, G2B_n, DataIn, GS_n, scan, out_ready,
        input  in_ready, DataOut, out_valid, scan_idx
    );

    modport slave (
        input  G1, G2A_n, G2B_n, DataIn, GS_n, scan, out_ready,
        output in_ready, DataOut, out_valid, scan_idx
    );
endinterface

// File: rtl/w_74hc138_sync.sv
// Clocked 74HC138-style decoder: captures a complemented priority code and holds it
// until acknowledged, or free-runs a one-hot-low scan across the eight lines.
module w_74hc138_sync #(
    parameter int SCAN_DIV = 4
) (
    input logic              clk,
    input logic              rst,
    w_74hc138_sync_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLD, SCAN} stateType;

    localparam logic [7:0] lastCount = 8'(SCAN_DIV - 1);

    stateType   stateReg, stateNext;
    logic [7:0] dataOutReg, dataOutNext;
    logic       outValidReg, outValidNext;
    logic [2:0] scanIdxReg, scanIdxNext;
    logic [7:0] prescaleReg, prescaleNext;

    logic       enabled;
    logic       inReady;
    logic [7:0] captureLine;

    function automatic logic [7:0] lowLine(input logic [2:0] idx);
        logic [7:0] line;
        line      = 8'hFF;
        line[idx] = 1'b0;
        return line;
    endfunction

    assign enabled = bus.G1 & ~bus.G2A_n & ~bus.G2B_n;
    assign inReady = (stateReg == IDLE) & enabled & ~bus.scan & ~rst;

    // The incoming code is complemented, so line gi is selected when ~DataIn == gi.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : genCapture
            assign captureLine[gi] = (~bus.DataIn != 3'(gi));
        end
    endgenerate

    always_comb begin
        stateNext    = stateReg;
        dataOutNext  = dataOutReg;
        outValidNext = outValidReg;
        scanIdxNext  = scanIdxReg;
        prescaleNext = prescaleReg;
        case (stateReg)
            IDLE: begin
                dataOutNext  = 8'hFF;
                outValidNext = 1'b0;
                if (enabled & bus.scan) begin
                    stateNext    = SCAN;
                    scanIdxNext  = 3'd0;
                    prescaleNext = 8'd0;
                    dataOutNext  = lowLine(3'd0);
                end else if (inReady & ~bus.GS_n) begin
                    stateNext    = HOLD;
                    dataOutNext  = captureLine;
                    outValidNext = 1'b1;
                end
            end
            HOLD: begin
                if (~enabled | bus.out_ready) begin
                    stateNext    = IDLE;
                    dataOutNext  = 8'hFF;
                    outValidNext = 1'b0;
                end
            end
            SCAN: begin
                outValidNext = 1'b0;
                if (~enabled | ~bus.scan) begin
                    // scan_idx deliberately keeps its last position on exit
                    stateNext   = IDLE;
                    dataOutNext = 8'hFF;
                end else if (prescaleReg == lastCount) begin
                    prescaleNext = 8'd0;
                    scanIdxNext  = scanIdxReg + 3'd1;
                    dataOutNext  = lowLine(scanIdxReg + 3'd1);
                end else begin
                    prescaleNext = prescaleReg + 8'd1;
                end
            end
            default: begin
                stateNext    = IDLE;
                dataOutNext  = 8'hFF;
                outValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            dataOutReg  <= 8'hFF;
            outValidReg <= 1'b0;
            scanIdxReg  <= 3'd0;
            prescaleReg <= 8'd0;
        end else begin
            stateReg    <= stateNext;
            dataOutReg  <= dataOutNext;
            outValidReg <= outValidNext;
            scanIdxReg  <= scanIdxNext;
            prescaleReg <= prescaleNext;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.DataOut   = dataOutReg;
    assign bus.out_valid = outValidReg;
    assign bus.scan_idx  = scanIdxReg;
endmodule

// File: tb/tb_w_74hc138_sync.sv
// Directed plus random stimulus for w_74hc138_sync, checked cycle by cycle against
// a mode/counter reference model built from the decoder's behavioural rules.
module tb_w_74hc138_sync;
    localparam int DIV = 4;
    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_SCAN = 2;

    logic clk = 1'b0;
    logic rst;
    w_74hc138_sync_if bus();

    w_74hc138_sync #(.SCAN_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFail = 0;

    // Reference model: which mode we are in, the held value, and cycles spent scanning.
    int         mMode = M_IDLE;
    logic [7:0] mHeld = 8'hFF;
    int         mCount = 0;
    int         mIdx = 0;

    function automatic logic modelEnabled();
        return bus.G1 && !bus.G2A_n && !bus.G2B_n;
    endfunction

    function automatic logic [7:0] expDataOut();
        logic [7:0] one;
        one = 8'd1;
        if (mMode == M_HOLD) return mHeld;
        if (mMode == M_SCAN) return 8'hFF ^ (one << mIdx);
        return 8'hFF;
    endfunction

    function automatic logic expInReady();
        return (mMode == M_IDLE) && modelEnabled() && !bus.scan && !rst;
    endfunction

    task automatic modelStep();
        logic       en;
        logic [7:0] one;
        one = 8'd1;
        en  = modelEnabled();
        if (rst) begin
            mMode = M_IDLE;
            mIdx  = 0;
        end else begin
            case (mMode)
                M_IDLE: begin
                    if (en && bus.scan) begin
                        mMode  = M_SCAN;
                        mCount = 0;
                        mIdx   = 0;
                    end else if (en && !bus.scan && !bus.GS_n) begin
                        mMode = M_HOLD;
                        mHeld = 8'hFF ^ (one << (7 - int'(bus.DataIn)));
                    end
                end
                M_HOLD: if (!en || bus.out_ready) mMode = M_IDLE;
                default: begin
                    if (!en || !bus.scan) begin
                        mMode = M_IDLE;
                    end else begin
                        mCount++;
                        mIdx = (mCount / DIV) % 8;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        #2;
        check("in_ready", {7'd0, bus.in_ready}, {7'd0, expInReady()});
        @(posedge clk);
        modelStep();
        #1;
        check("DataOut", bus.DataOut, expDataOut());
        check("out_valid", {7'd0, bus.out_valid}, {7'd0, mMode == M_HOLD});
        check("scan_idx", {5'd0, bus.scan_idx}, 8'(mIdx));
        $display("t=%0t rst=%b en=%b%b%b scan=%b GS_n=%b DataIn=%b rdy=%b -> DataOut=%h vld=%b idx=%0d",
                 $time, rst, bus.G1, bus.G2A_n, bus.G2B_n, bus.scan, bus.GS_n, bus.DataIn,
                 bus.out_ready, bus.DataOut, bus.out_valid, bus.scan_idx);
    endtask

    initial begin
        rst = 1'b1;
        bus.G1 = 1'b1; bus.G2A_n = 1'b0; bus.G2B_n = 1'b0;
        bus.DataIn = 3'b111; bus.GS_n = 1'b1; bus.scan = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        check("reset_dataout", bus.DataOut, 8'hFF);

        // Capture immediately after reset, then acknowledge
        rst = 1'b0; bus.DataIn = 3'b000; bus.GS_n = 1'b0;
        tick();
        check("capture_7F", bus.DataOut, 8'h7F);
        bus.GS_n = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("release_FF", bus.DataOut, 8'hFF);
        bus.out_ready = 1'b0;

        // Strobe gating
        bus.DataIn = 3'b110; bus.GS_n = 1'b1;
        tick();
        check("gated_FF", bus.DataOut, 8'hFF);
        bus.GS_n = 1'b0;
        tick();
        check("capture_FD", bus.DataOut, 8'hFD);
        bus.GS_n = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Hold protection
        bus.DataIn = 3'b111; bus.GS_n = 1'b0;
        tick();
        check("hold_FE", bus.DataOut, 8'hFE);
        bus.DataIn = 3'b000;
        tick();
        check("hold_ignores", bus.DataOut, 8'hFE);
        bus.out_ready = 1'b1;
        tick();
        check("release_no_capture", bus.DataOut, 8'hFF);
        bus.out_ready = 1'b0; bus.GS_n = 1'b1;
        tick();
        check("still_idle", bus.DataOut, 8'hFF);

        // Scan with wrap-around
        bus.scan = 1'b1;
        for (int k = 0; k < 36; k++) begin
            logic [7:0] one;
            one = 8'd1;
            tick();
            check("scan_walk", bus.DataOut, 8'hFF ^ (one << ((k / DIV) % 8)));
        end

        // Reset mid-scan
        rst = 1'b1;
        tick(); tick();
        check("rst_scan_FF", bus.DataOut, 8'hFF);
        check("rst_scan_idx", {5'd0, bus.scan_idx}, 8'd0);
        rst = 1'b0; bus.scan = 1'b0;

        // Disable during HOLD
        bus.DataIn = 3'b010; bus.GS_n = 1'b0;
        tick();
        check("hold_DF", bus.DataOut, 8'hDF);
        bus.G2A_n = 1'b1;
        tick();
        check("disable_hold", bus.DataOut, 8'hFF);
        bus.G2A_n = 1'b0; bus.GS_n = 1'b1;

        // Disable during SCAN, then scan_idx retained
        bus.scan = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        bus.G2A_n = 1'b1;
        tick();
        check("disable_scan", bus.DataOut, 8'hFF);
        check("idx_retained", {5'd0, bus.scan_idx}, 8'd2);
        tick();
        bus.G2A_n = 1'b0; bus.scan = 1'b0;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            rst           = ($urandom_range(0, 31) == 0);
            bus.G1        = ($urandom_range(0, 15) != 0);
            bus.G2A_n     = ($urandom_range(0, 15) == 0);
            bus.G2B_n     = ($urandom_range(0, 15) == 0);
            bus.DataIn    = 3'($urandom_range(0, 7));
            bus.GS_n      = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) bus.scan = ~bus.scan;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule

// File: doc/w_74hc138_sync.md
W_74HC138_SYNC -- requirements
Module: w_74hc138_sync

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, giving the number of clk cycles per scan step (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port G1  input  1  enable, active-high.
REQ-005 SHALL have port G2A_n  input  1  enable, active-low.
REQ-006 SHALL have port G2B_n  input  1  enable, active-low.
REQ-007 SHALL have port DataIn  input  3  complemented priority code, as produced by the 8-to-3 priority encoder.
REQ-008 SHALL have port GS_n  input  1  code-valid strobe, active-low.
REQ-009 SHALL have port scan  input  1  requests the free-running scan mode.
REQ-010 SHALL have port out_ready  input  1  consumer acknowledge of a held output.
REQ-011 SHALL have port in_ready  output  1  decoder can accept a code this cycle.
REQ-012 SHALL have port DataOut  output  8  registered one-hot output, active-low.
REQ-013 SHALL have port out_valid  output  1  DataOut holds a captured code.
REQ-014 SHALL have port scan_idx  output  3  current scan position.

Function
REQ-015 SHALL define enabled = G1 & ~G2A_n & ~G2B_n.
REQ-016 SHALL decode index = ~DataIn; the selected line is DataOut[index] = 0, all other lines 1. Example: DataIn=000 gives 8'h7F.
REQ-017 SHALL implement the FSM states IDLE, HOLD and SCAN; the reset state is IDLE.
REQ-018 SHALL drive in_ready combinationally as (state==IDLE) & enabled & ~scan & ~rst.
REQ-019 IDLE: SHALL capture when in_ready & ~GS_n, then go to HOLD; DataOut and out_valid update at that same edge, giving 1-cycle latency.
REQ-020 IDLE: SHALL go to SCAN when enabled & scan; scan SHALL take priority over GS_n in the same cycle.
REQ-021 IDLE: SHALL keep DataOut=8'hFF and out_valid=0.
REQ-022 HOLD: SHALL keep DataOut stable with out_valid=1, and SHALL ignore new codes (in_ready=0).
REQ-023 HOLD: on out_ready=1, SHALL go to IDLE at the next edge with DataOut=8'hFF and out_valid=0; a code present in that same cycle SHALL NOT be captured.
REQ-024 HOLD: if enabled drops, SHALL abandon the held code and go to IDLE at the next edge, with DataOut=8'hFF and out_valid=0, irrespective of out_ready.
REQ-025 SCAN: SHALL drive DataOut low on line scan_idx with out_valid=0, and SHALL keep a prescale counter 0..SCAN_DIV-1.
REQ-026 SCAN: when the prescale counter reaches SCAN_DIV-1, SHALL advance scan_idx by 1 modulo 8 (7 wraps to 0).
REQ-027 SCAN: on entry, SHALL set scan_idx=0 and prescale=0, so the first step lasts exactly SCAN_DIV cycles.
REQ-028 SCAN: when scan=0 or enabled=0, SHALL go to IDLE at the next edge with DataOut=8'hFF; scan_idx SHALL retain its last value.
REQ-029 With SCAN_DIV=1, SHALL advance scan_idx every cycle.
REQ-030 SHALL ignore GS_n and DataIn while in SCAN.
REQ-031 SHALL register all outputs except in_ready.

Reset
REQ-032 With rst=1 at an edge, SHALL set state=IDLE, DataOut=8'hFF, out_valid=0, scan_idx=0 and prescale=0.
REQ-033 SHALL give rst priority over every other input, including during HOLD and SCAN; in_ready SHALL be 0 while rst=1.
REQ-034 The first capture after rst deasserts SHALL be possible in the cycle immediately following the reset edge.

Verification
REQ-035 Reset: rst=1 for 2 cycles mid-SCAN -> DataOut=8'hFF, out_valid=0, scan_idx=0, in_ready=0 during rst.
REQ-036 Capture: enabled, DataIn=3'b000, GS_n=0 for 1 cycle -> next cycle DataOut=8'h7F, out_valid=1; then out_ready=1 -> next cycle DataOut=8'hFF, out_valid=0.
REQ-037 Strobe gating: DataIn=3'b110 with GS_n=1 -> DataOut stays 8'hFF; then GS_n=0 -> DataOut=8'hFD.
REQ-038 Hold protection: in HOLD (8'hFE), present DataIn=3'b000 with GS_n=0 -> DataOut stays 8'hFE; with out_ready=1 in the same cycle -> 8'hFF, and the new code is not captured.
REQ-039 Scan: SCAN_DIV=4, scan=1 -> DataOut 8'hFE x4 cycles, 8'hFD x4, ..., 8'h7F x4, then 8'hFE again (wrap-around).
REQ-040 Disable: G2A_n=1 asserted during HOLD and during SCAN -> next cycle DataOut=8'hFF, out_valid=0, in_ready=0.
